// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package ifu_fetch_pkg;

    localparam int CPU_WIDTH = 64;

    localparam logic [31:0]          INST_NOP       = 32'h0000_0013;
    localparam logic [CPU_WIDTH-1:0] DEFAULT_RST_PC = 64'h8000_0000;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        KILL,
        HOLD
    } fetch_state_e;

endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and memory (slave).
interface ifu_fetch_if;
    import ifu_fetch_pkg::*;

    logic                 o_imem_valid;
    logic                 i_imem_ready;
    logic [CPU_WIDTH-1:0] o_imem_addr;
    logic                 i_imem_rvalid;
    logic [31:0]          i_imem_rdata;

    modport master (
        output o_imem_valid,
        output o_imem_addr,
        input  i_imem_ready,
        input  i_imem_rvalid,
        input  i_imem_rdata
    );

    modport slave (
        input  o_imem_valid,
        input  o_imem_addr,
        output i_imem_ready,
        output i_imem_rvalid,
        output i_imem_rdata
    );

endinterface

// File: rtl/ifu_fetch_ifid_reg.sv
// IF/ID pipeline register: hold on stall, load on advance, flush to a NOP bubble on redirect.
module ifid_reg
    import ifu_fetch_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_hold,
    input  logic                 i_load,
    input  logic                 i_flush,
    input  logic [CPU_WIDTH-1:0] i_pc,
    input  logic [31:0]          i_inst,
    output logic                 o_valid,
    output logic [CPU_WIDTH-1:0] o_pc,
    output logic [31:0]          o_inst
);

    logic                 valid_q;
    logic [CPU_WIDTH-1:0] pc_q;
    logic [31:0]          inst_q;

    // A flush keeps the old PC so the branch unit still sees a sensible i_idupc.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= INST_NOP;
        end else if (!i_hold) begin
            if (i_flush) begin
                valid_q <= 1'b0;
                inst_q  <= INST_NOP;
            end else if (i_load) begin
                valid_q <= 1'b1;
                pc_q    <= i_pc;
                inst_q  <= i_inst;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign o_valid = valid_q;
    assign o_pc    = pc_q;
    assign o_inst  = inst_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: fetch PC, one-outstanding imem request FSM with kill and
// skid-buffer states, driving the IF/ID register.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [CPU_WIDTH-1:0] RST_PC = DEFAULT_RST_PC
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    ifu_fetch_if.master          imem,
    input  logic [CPU_WIDTH-1:0] i_next_pc,
    input  logic                 i_ifid_nop,
    input  logic                 i_stall,
    output logic [CPU_WIDTH-1:0] o_ifu_pc,
    output logic                 o_id_valid,
    output logic [CPU_WIDTH-1:0] o_id_pc,
    output logic [31:0]          o_id_inst
);

    fetch_state_e         state_q, state_d;
    logic [CPU_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]          buf_q, buf_d;
    logic                 imem_valid_q;

    logic                 redir;
    logic                 avail;
    logic                 adv;
    logic                 accept;
    logic [31:0]          fetch_inst;

    assign redir      = i_ifid_nop & o_id_valid & ~i_stall;
    assign avail      = ((state_q == WAIT) & imem.i_imem_rvalid) | (state_q == HOLD);
    assign adv        = avail & ~i_stall & ~redir;
    assign accept     = imem_valid_q & imem.i_imem_ready;
    assign fetch_inst = (state_q == HOLD) ? buf_q : imem.i_imem_rdata;
    assign pc_d       = (adv | redir) ? i_next_pc : pc_q;

    // KILL absorbs the response of a fetch that a redirect made stale.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        case (state_q)
            REQ: begin
                if (accept) begin
                    state_d = redir ? KILL : WAIT;
                end
            end
            WAIT: begin
                if (imem.i_imem_rvalid) begin
                    if (redir) begin
                        state_d = REQ;
                    end else if (i_stall) begin
                        state_d = HOLD;
                        buf_d   = imem.i_imem_rdata;
                    end else begin
                        state_d = REQ;
                    end
                end else if (redir) begin
                    state_d = KILL;
                end
            end
            KILL: begin
                if (imem.i_imem_rvalid) begin
                    state_d = REQ;
                end
            end
            HOLD: begin
                if (!i_stall) begin
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    // Request valid is registered so it stays low throughout reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= REQ;
            pc_q         <= RST_PC;
            buf_q        <= '0;
            imem_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            buf_q        <= buf_d;
            imem_valid_q <= (state_d == REQ);
        end
    end

    assign imem.o_imem_valid = imem_valid_q;
    assign imem.o_imem_addr  = pc_q;
    assign o_ifu_pc          = pc_q;

    ifid_reg u_ifid_reg (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_hold  (i_stall),
        .i_load  (adv),
        .i_flush (redir),
        .i_pc    (pc_q),
        .i_inst  (fetch_inst),
        .o_valid (o_id_valid),
        .o_pc    (o_id_pc),
        .o_inst  (o_id_inst)
    );

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized scoreboard bench for ifu_fetch: a transaction-level memory/branch-unit model
// predicts every cycle's PC and IF/ID contents; a monitor compares them against the DUT.
module tb_ifu_fetch;
    import ifu_fetch_pkg::*;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        rstN;
    logic [63:0] nextPc;
    logic        ifidNop;
    logic        stall;
    logic [63:0] ifuPc;
    logic        idValid;
    logic [63:0] idPc;
    logic [31:0] idInst;

    ifu_fetch_if imemBus ();

    ifu_fetch #(.RST_PC(RESET_PC)) dut (
        .i_clk      (clock),
        .i_rst_n    (rstN),
        .imem       (imemBus.master),
        .i_next_pc  (nextPc),
        .i_ifid_nop (ifidNop),
        .i_stall    (stall),
        .o_ifu_pc   (ifuPc),
        .o_id_valid (idValid),
        .o_id_pc    (idPc),
        .o_id_inst  (idInst)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] pc;
        logic        reqOut;
        logic        idValid;
        logic        nopCheck;
        logic [63:0] idPc;
    } cycleExp_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } idExp_t;

    cycleExp_t cycQ[$];
    idExp_t    idQ[$];

    int vecCount  = 0;
    int missCount = 0;

    // Abstract model: where the fetch stream is, whether a fetch is outstanding/stale/buffered.
    logic [63:0] mPc;
    logic        mIdValid;
    logic [63:0] mIdPc;
    logic        mReqOut;
    logic        mInflight;
    logic        mKilled;
    logic        mBufValid;
    logic [31:0] mBufData;
    int          mCnt;

    int pStall, pNop, pReady, maxLat;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        mPc       = RESET_PC;
        mIdValid  = 1'b0;
        mIdPc     = '0;
        mReqOut   = 1'b0;
        mInflight = 1'b0;
        mKilled   = 1'b0;
        mBufValid = 1'b0;
        mBufData  = '0;
        mCnt      = 0;
    endtask

    task automatic quietInputs();
        ifidNop                = 1'b0;
        stall                  = 1'b0;
        nextPc                 = '0;
        imemBus.i_imem_ready   = 1'b0;
        imemBus.i_imem_rvalid  = 1'b0;
        imemBus.i_imem_rdata   = '0;
    endtask

    // Drive one cycle of branch-unit/memory stimulus and push what must be visible after the edge.
    task automatic applyStimulus();
        logic        doStall, doNop, doReady, rvalid, redir, rspLive, avail, adv, accept;
        logic [31:0] rdata, availInst;
        logic [63:0] target, drivenNext;
        logic        nopChk;
        idExp_t      idE;
        cycleExp_t   cycE;

        doStall = ($urandom_range(99) < pStall);
        doNop   = ($urandom_range(99) < pNop);
        doReady = ($urandom_range(99) < pReady);
        rvalid  = 1'b0;
        rdata   = '0;
        if (mInflight) begin
            mCnt--;
            if (mCnt == 0) begin
                rvalid = 1'b1;
                rdata  = $urandom;
            end
        end
        target     = RESET_PC + 64'($urandom_range(1023)) * 64'd4;
        redir      = doNop & mIdValid & ~doStall;
        rspLive    = rvalid & ~mKilled;
        avail      = rspLive | mBufValid;
        availInst  = mBufValid ? mBufData : rdata;
        adv        = avail & ~doStall & ~redir;
        accept     = mReqOut & doReady;
        drivenNext = redir ? target : mPc + 64'd4;

        ifidNop               = doNop;
        stall                 = doStall;
        nextPc                = drivenNext;
        imemBus.i_imem_ready  = doReady;
        imemBus.i_imem_rvalid = rvalid;
        imemBus.i_imem_rdata  = rdata;

        nopChk = 1'b0;
        if (adv) begin
            idE.pc   = mPc;
            idE.inst = availInst;
            idQ.push_back(idE);
            mIdValid = 1'b1;
            mIdPc    = mPc;
        end else if (redir) begin
            mIdValid = 1'b0;
            nopChk   = 1'b1;
        end else if (!doStall) begin
            mIdValid = 1'b0;
        end

        if (mBufValid && !doStall) mBufValid = 1'b0;
        if (rvalid) begin
            mInflight = 1'b0;
            if (!mKilled && !redir && doStall) begin
                mBufValid = 1'b1;
                mBufData  = rdata;
            end
            mKilled = 1'b0;
        end
        if (redir && mInflight) mKilled = 1'b1;
        if (accept) begin
            mInflight = 1'b1;
            mKilled   = redir;
            mCnt      = $urandom_range(maxLat, 1);
        end
        if (adv || redir) mPc = drivenNext;
        mReqOut = !mInflight && !mBufValid;

        cycE.pc       = mPc;
        cycE.reqOut   = mReqOut;
        cycE.idValid  = mIdValid;
        cycE.nopCheck = nopChk;
        cycE.idPc     = mIdPc;
        cycQ.push_back(cycE);
    endtask

    task automatic runPhase(input int n, input int ps, input int pn, input int pr, input int ml);
        pStall = ps;
        pNop   = pn;
        pReady = pr;
        maxLat = ml;
        repeat (n) begin
            applyStimulus();
            @(negedge clock);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_imem_valid"}, 64'(imemBus.o_imem_valid), 64'd0);
        checkOutput({tag, "_ifu_pc"}, ifuPc, RESET_PC);
        checkOutput({tag, "_imem_addr"}, imemBus.o_imem_addr, RESET_PC);
        checkOutput({tag, "_id_valid"}, 64'(idValid), 64'd0);
        checkOutput({tag, "_id_pc"}, idPc, 64'd0);
        checkOutput({tag, "_id_inst"}, 64'(idInst), 64'(NOP_INST));
    endtask

    // Monitor: per-cycle expectations plus every new instruction entering ID.
    logic        prevValid = 1'b0;
    logic [63:0] prevPc    = '0;
    logic [31:0] prevInst  = '0;

    initial begin
        cycleExp_t e;
        idExp_t    d;
        forever begin
            @(posedge clock);
            #1;
            if (cycQ.size() > 0) begin
                e = cycQ.pop_front();
                checkOutput("ifu_pc", ifuPc, e.pc);
                checkOutput("imem_addr", imemBus.o_imem_addr, e.pc);
                checkOutput("imem_valid", 64'(imemBus.o_imem_valid), 64'(e.reqOut));
                checkOutput("id_valid", 64'(idValid), 64'(e.idValid));
                if (e.nopCheck) begin
                    checkOutput("flush_inst", 64'(idInst), 64'(NOP_INST));
                    checkOutput("flush_pc", idPc, e.idPc);
                end
            end
            if (idValid && (!prevValid || idPc != prevPc || idInst != prevInst)) begin
                checkOutput("id_load_expected", 64'(idQ.size() > 0), 64'd1);
                if (idQ.size() > 0) begin
                    d = idQ.pop_front();
                    checkOutput("id_pc", idPc, d.pc);
                    checkOutput("id_inst", 64'(idInst), 64'(d.inst));
                end
            end
            prevValid = idValid;
            prevPc    = idPc;
            prevInst  = idInst;
        end
    end

    initial begin
        int guard;
        rstN = 1'b0;
        quietInputs();
        modelReset();
        repeat (3) @(negedge clock);
        checkReset("por");
        rstN = 1'b1;

        runPhase(20, 0, 0, 100, 1);
        runPhase(200, 0, 40, 100, 3);
        runPhase(200, 50, 20, 100, 2);
        runPhase(200, 10, 30, 20, 2);
        runPhase(600, 30, 30, 60, 4);

        // Pulse reset while a fetch is outstanding.
        pStall = 0;
        pNop   = 0;
        pReady = 100;
        maxLat = 4;
        guard  = 0;
        while (!(mInflight && !mKilled && mCnt > 1) && guard < 200) begin
            applyStimulus();
            @(negedge clock);
            guard++;
        end
        checkOutput("reach_wait_in_budget", 64'(guard < 200), 64'd1);
        quietInputs();
        #2 rstN = 1'b0;
        #1 checkReset("mid");
        @(negedge clock);
        @(negedge clock);
        checkReset("mid_held");
        rstN = 1'b1;
        modelReset();

        runPhase(400, 25, 25, 70, 3);

        checkOutput("id_queue_drained", 64'(idQ.size()), 64'd0);
        checkOutput("cycle_queue_drained", 64'(cycQ.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction-fetch stage: owns the architectural fetch PC, issues one instruction-memory request at a time over a valid/ready handshake, and drives the IF/ID pipeline register. It sits directly upstream of the branch unit. The branch unit reads `o_ifu_pc` and the ID-stage instruction and returns `i_next_pc` and `i_ifid_nop`. This block applies those results to update the PC, flush IF/ID and kill any in-flight fetch.

## Interface
- `RST_PC`, default 64'h8000_0000: PC value loaded on reset.
- `i_clk`, input, 1: core clock; all state updates on its rising edge.
- `i_rst_n`, input, 1: asynchronous active-low reset.
- `i_next_pc`, input, `CPU_WIDTH`: PC to fetch after the current one. It equals `o_ifu_pc+4` unless the branch unit is redirecting.
- `i_ifid_nop`, input, 1: branch unit's redirect/flush request for the instruction held in ID.
- `i_stall`, input, 1: hazard-unit stall; holds the PC and IF/ID.
- `o_imem_valid`, output, 1: fetch request valid.
- `i_imem_ready`, input, 1: memory accepts the request.
- `o_imem_addr`, output, `CPU_WIDTH`: fetch address; always equals `o_ifu_pc`.
- `i_imem_rvalid`, input, 1: fetch response valid.
- `i_imem_rdata`, input, 32: fetched instruction.
- `o_ifu_pc`, output, `CPU_WIDTH`: current fetch PC; feeds the branch unit's `i_ifupc`.
- `o_id_valid`, output, 1: IF/ID holds a real instruction.
- `o_id_pc`, output, `CPU_WIDTH`: PC of the ID instruction; feeds the branch unit's `i_idupc`.
- `o_id_inst`, output, 32: ID instruction.

## Operation
- Redirect is `redir = i_ifid_nop & o_id_valid & ~i_stall`. The branch unit's output is ignored while ID holds a bubble or is stalled.
- A fetch is accepted when `o_imem_valid & i_imem_ready`. At most one fetch is outstanding.
- The memory never returns `i_imem_rvalid` in the same cycle as the acceptance.
- `o_imem_valid` is 1 only in state REQ.
- The memory samples `o_imem_addr` only on the acceptance cycle, so the address may change while valid is high without ready.
- Advance (`adv`): an instruction is available (`i_imem_rvalid` in WAIT, or the buffer in HOLD), `~i_stall`, and no `redir`. On `adv`:
  - IF/ID loads `{o_ifu_pc, inst}` and `o_id_valid` goes to 1.
  - PC loads `i_next_pc`.
- On `redir`:
  - PC loads `i_next_pc`.
  - IF/ID becomes a bubble: `o_id_valid`=0, `o_id_inst`=NOP 32'h0000_0013, `o_id_pc` holds its value.
  - Any fetched or buffered instruction is discarded.
- When neither `adv` nor `redir` occurs and `~i_stall`: `o_id_valid` is cleared (bubble). When `i_stall`: IF/ID holds.
- FSM states and transitions:
  - REQ:
    - Accepted and `redir` in the same cycle: the old-PC fetch is in flight. Go to KILL and load the new PC.
    - Accepted only: go to WAIT.
    - `redir` only: load the PC and stay in REQ.
  - WAIT:
    - `rvalid & redir`: drop the response, load the PC, go to REQ.
    - `rvalid & i_stall`: capture rdata into the buffer, go to HOLD.
    - `rvalid` with `adv`: go to REQ.
    - `~rvalid & redir`: load the PC, go to KILL.
    - Otherwise: stay.
  - KILL: on `rvalid`, drop the response and go to REQ. A `redir` here updates the PC and stays in KILL.
  - HOLD:
    - `~i_stall & redir`: discard the buffer, go to REQ.
    - `~i_stall` otherwise: `adv` from the buffer, go to REQ.
    - `i_stall`: stay.
- Reset values: state REQ, `o_ifu_pc`=`RST_PC`, `o_id_valid`=0, `o_id_pc`=0, `o_id_inst`=NOP, buffer=0. `o_imem_valid` is 0 while `i_rst_n`=0 and 1 from the first cycle after release.
- Reset asserted mid-fetch returns immediately to the reset values. The outstanding response is lost; the memory is reset by the same `i_rst_n`.

## Timing
- Best-case fetch: request accepted in cycle N, `rvalid` in N+1, IF/ID updated at the end of N+1, next request in N+2. Peak throughput is 1 instruction per 2 cycles.
- Taken branch or jump: redirect occurs in the cycle the instruction sits in ID. The target request is issued the next cycle, or later if a kill is pending. Exactly one bubble enters ID per redirect.
- Redirect and response in the same cycle: redirect wins; the response is never written to IF/ID.
- `i_stall` with no response pending has no effect on the FSM other than blocking `adv`.

## Structure
- In the shared package / `config.sv`:
  - FSM state enum `{REQ, WAIT, KILL, HOLD}`.
  - `INST_NOP` = 32'h0000_0013.
  - Default `RST_PC`.
  - `CPU_WIDTH` = 64.
- One sub-module, `ifid_reg`: the IF/ID register with hold (stall), load (`adv`) and flush (`redir`), async active-low reset.
- FSM, PC register and skid buffer live in `ifu_fetch`.

## Test plan
- **Reset release, memory ready=1, 1-cycle latency, rdata 32'h00000093:**
  - `o_imem_addr` is 8000_0000; `o_id_pc`=8000_0000 and `o_id_inst`=00000093 two cycles after release.
  - Next request to 8000_0004.
- **Jump in ID, `i_ifid_nop`=1, `i_next_pc`=8000_0100, while in WAIT:**
  - State goes to KILL and the late response is dropped.
  - Next accepted address is 8000_0100; `o_id_valid`=0 for one bubble.
- **Response arriving with `i_stall`=1 for 3 cycles:**
  - Instruction held in HOLD; IF/ID unchanged during the stall.
  - On release, IF/ID loads the buffered instruction and the PC advances by 4.
- **`i_ready`=0 for 5 cycles:**
  - `o_imem_valid` stays 1 and the address is stable; no IF/ID update.
  - Redirect during this window changes `o_imem_addr` to the target with no kill.
- **`redir` and `rvalid` in the same cycle:** response discarded, PC equals target, `o_id_inst`=NOP.
- **`i_rst_n` pulsed low in WAIT:** all outputs return to reset values asynchronously, and fetch restarts at `RST_PC`.
